// File: rtl/ifetch_queue.sv
// Instruction fetch unit with an in-order prefetch queue.
// It keeps at most one memory request in flight, accepts redirects, and presents the queue head to decode.
module ifetch_queue #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                          clock,
  input  logic                          reset,
  output logic                          imem_req,
  output logic [ADDR_WIDTH-1:0]         imem_addr,
  input  logic                          imem_ready,
  input  logic                          imem_valid,
  input  logic [31:0]                   imem_rdata,
  input  logic                          redirect,
  input  logic [ADDR_WIDTH-1:0]         redirect_pc,
  output logic                          inst_valid,
  output logic [31:0]                   inst,
  output logic [ADDR_WIDTH-1:0]         inst_pc,
  output logic [ADDR_WIDTH-1:0]         link_addr,
  input  logic                          inst_ready,
  output logic [$clog2(DEPTH):0]        queue_count,
  output logic [1:0]                    fsm_state
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] FOUR = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   req_pc_q, req_pc_d;
  logic                    stale_q, stale_d;
  logic [PW-1:0]           head_q, head_d;
  logic [PW-1:0]           tail_q, tail_d;
  logic [CW-1:0]           count_q, count_d;
  logic [ADDR_WIDTH-1:0]   mem_pc_q   [DEPTH];
  logic [31:0]             mem_data_q [DEPTH];

  logic head_valid;
  logic accept;
  logic push;
  logic pop;
  logic fresh_resp;
  logic unused_ok;

  assign unused_ok = ^redirect_pc[1:0];

  // At most one request in flight, so in FETCH nothing is pending and count alone bounds the queue.
  assign imem_req   = reset && (state_q == S_FETCH) && !redirect && (count_q < FULL);
  assign accept     = imem_req && imem_ready;
  assign head_valid = (count_q != '0);

  // stale_q marks a response still owed for a request issued before a reset.
  assign fresh_resp = imem_valid && !stale_q;
  assign push       = reset && (state_q == S_WAIT) && fresh_resp && !redirect;
  assign pop        = reset && head_valid && inst_ready && !redirect;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    stale_d  = stale_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;

    if (imem_valid && stale_q) begin
      stale_d = 1'b0;
    end

    case (state_q)
      S_FETCH: begin
        if (accept) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fresh_resp)    state_d = S_FETCH;
        else if (redirect) state_d = S_DISCARD;
      end
      S_DISCARD: begin
        if (fresh_resp) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (accept) begin
      pc_d     = pc_q + FOUR;
      req_pc_d = pc_q;
    end

    // Redirect flushes the queue and overrides any push, pop or PC increment.
    if (redirect) begin
      pc_d    = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      stale_q  <= ((state_q != S_FETCH) || stale_q) && !imem_valid;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      stale_q  <= stale_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_pc_q[tail_q]   <= req_pc_q;
      mem_data_q[tail_q] <= imem_rdata;
    end
  end

  // Outputs are forced to their idle values while reset is held low.
  assign inst_valid  = reset && head_valid;
  assign inst        = inst_valid ? mem_data_q[head_q] : '0;
  assign inst_pc     = inst_valid ? mem_pc_q[head_q] : '0;
  assign link_addr   = inst_valid ? (mem_pc_q[head_q] + FOUR) : '0;
  assign imem_addr   = reset ? pc_q : RESET_PC;
  assign queue_count = reset ? count_q : '0;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: in-order memory model with programmable latency, hand-computed checks.
module tb_ifetch_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] link_addr;
  logic        inst_ready = 1'b0;
  logic [2:0]  queue_count;
  logic [1:0]  fsm_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int lat   = 1;
  bit sb_on = 1'b0;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_q[$];

  ifetch_queue #(.ADDR_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .link_addr   (link_addr),
    .inst_ready  (inst_ready),
    .queue_count (queue_count),
    .fsm_state   (fsm_state)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: record acceptance, advance to the falling edge, drive inputs, let outputs settle.
  task automatic step(input logic rst, input logic ir, input logic rd, input logic [31:0] rpc);
    logic [31:0] e;
    if (imem_req && imem_ready) begin
      pend_addr.push_back(imem_addr);
      pend_due.push_back(cyc + lat);
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
    reset       = rst;
    inst_ready  = ir;
    redirect    = rd;
    redirect_pc = rpc;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_valid = 1'b1;
      imem_rdata = word(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_valid = 1'b0;
      imem_rdata = '0;
    end
    #1;
    if (sb_on && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_extra_pop", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", inst_pc, e);
        check("sb_inst", inst, word(e));
        check("sb_link", link_addr, e + 32'd4);
      end
    end
  endtask

  task automatic do_reset();
    repeat (2) step(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 8 && pend_due.size() > 0; i++) step(1'b0, 1'b0, 1'b0, '0);
    lat = 1;
  endtask

  initial begin
    // Reset values
    step(1'b0, 1'b1, 1'b0, '0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_count", 32'(queue_count), 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_link", link_addr, 32'h0);
    check("rst_state", 32'(fsm_state), 32'd0);
    step(1'b0, 1'b1, 1'b0, '0);

    // Sequential stream, latency 1, decode always ready
    for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
    sb_on = 1'b1;
    step(1'b1, 1'b1, 1'b0, '0);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);
    step(1'b1, 1'b1, 1'b0, '0);
    check("lat_wait_state", 32'(fsm_state), 32'd1);
    check("lat_not_yet", 32'(inst_valid), 32'd0);
    check("lat_no_req", 32'(imem_req), 32'd0);
    step(1'b1, 1'b1, 1'b0, '0);
    check("lat_valid", 32'(inst_valid), 32'd1);
    repeat (18) step(1'b1, 1'b1, 1'b0, '0);
    sb_on = 1'b0;
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // Saturation with decode stalled, then in-order drain
    do_reset();
    repeat (20) step(1'b1, 1'b0, 1'b0, '0);
    check("sat_count", 32'(queue_count), 32'd4);
    check("sat_req", 32'(imem_req), 32'd0);
    check("sat_head_pc", inst_pc, 32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    sb_on = 1'b1;
    repeat (4) step(1'b1, 1'b1, 1'b0, '0);
    sb_on = 1'b0;
    check("sat_drained", 32'(exp_q.size()), 32'd0);
    step(1'b1, 1'b0, 1'b0, '0);

    // Redirect while a response is outstanding
    do_reset();
    lat = 2;
    repeat (7) step(1'b1, 1'b0, 1'b0, '0);
    check("rw_pre_count", 32'(queue_count), 32'd2);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0103);
    check("rw_in_wait", 32'(fsm_state), 32'd1);
    check("rw_no_req", 32'(imem_req), 32'd0);
    step(1'b1, 1'b0, 1'b0, '0);
    check("rw_count0", 32'(queue_count), 32'd0);
    check("rw_empty", 32'(inst_valid), 32'd0);
    check("rw_discard", 32'(fsm_state), 32'd2);
    check("rw_addr", imem_addr, 32'h100);
    step(1'b1, 1'b0, 1'b0, '0);
    check("rw_refetch_req", 32'(imem_req), 32'd1);
    check("rw_refetch_addr", imem_addr, 32'h100);
    repeat (3) step(1'b1, 1'b0, 1'b0, '0);
    check("rw_new_valid", 32'(inst_valid), 32'd1);
    check("rw_new_pc", inst_pc, 32'h100);
    check("rw_new_inst", inst, word(32'h100));
    check("rw_new_link", link_addr, 32'h104);
    check("rw_new_count", 32'(queue_count), 32'd1);

    // Redirect together with a response and a pop
    do_reset();
    repeat (3) step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    check("rc_pre_valid", 32'(inst_valid), 32'd1);
    check("rc_pre_pc", inst_pc, 32'h0);
    step(1'b1, 1'b0, 1'b0, '0);
    check("rc_count0", 32'(queue_count), 32'd0);
    check("rc_empty", 32'(inst_valid), 32'd0);
    check("rc_req", 32'(imem_req), 32'd1);
    check("rc_addr", imem_addr, 32'h200);
    repeat (2) step(1'b1, 1'b0, 1'b0, '0);
    check("rc_new_pc", inst_pc, 32'h200);
    check("rc_new_count", 32'(queue_count), 32'd1);

    // Address wrap at the top of memory
    do_reset();
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check("wr_redir_noreq", 32'(imem_req), 32'd0);
    step(1'b1, 1'b0, 1'b0, '0);
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    repeat (2) step(1'b1, 1'b0, 1'b0, '0);
    check("wr_pc", inst_pc, 32'hFFFF_FFFC);
    check("wr_link", link_addr, 32'h0);
    check("wr_inst", inst, word(32'hFFFF_FFFC));
    check("wr_next_addr", imem_addr, 32'h0);
    check("wr_next_req", 32'(imem_req), 32'd1);

    // Reset with a request outstanding: late response must be dropped
    do_reset();
    lat = 4;
    step(1'b1, 1'b0, 1'b1, 32'h0000_0040);
    step(1'b1, 1'b0, 1'b0, '0);
    check("rs_pre_addr", imem_addr, 32'h40);
    step(1'b0, 1'b0, 1'b0, '0);
    check("rs_rst_req", 32'(imem_req), 32'd0);
    check("rs_rst_addr", imem_addr, 32'h0);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    check("rs_first_req", 32'(imem_req), 32'd1);
    check("rs_first_addr", imem_addr, 32'h0);
    lat = 2;
    step(1'b1, 1'b0, 1'b0, '0);
    check("rs_stale_wait", 32'(fsm_state), 32'd1);
    step(1'b1, 1'b0, 1'b0, '0);
    check("rs_stale_dropped", 32'(inst_valid), 32'd0);
    check("rs_stale_count", 32'(queue_count), 32'd0);
    step(1'b1, 1'b0, 1'b0, '0);
    check("rs_valid", 32'(inst_valid), 32'd1);
    check("rs_pc", inst_pc, 32'h0);
    check("rs_inst", inst, word(32'h0));
    check("rs_count", 32'(queue_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
